// File: rtl/bsg_manycore_vcache_pkg.sv
// ---------------------------------------------------------------------------
// bsg_manycore_vcache_pkg
// Shared types and defaults for the multi-bank vcache tile DMA logic.
//   - arb_state_e               : packet-arbiter lock state
//   - vcache_dma_conc_stats_s   : per-bank concentrator statistics record
//   - vcache_dma_burst_len_gp   : default beats per DMA block
//   - vcache_dma_id_els_gp      : default depth of each outstanding-ID FIFO
//   - dma_pkt_width()           : width of a bsg_cache DMA packet
// ---------------------------------------------------------------------------
package bsg_manycore_vcache_pkg;

   localparam int vcache_dma_burst_len_gp = 8;
   localparam int vcache_dma_id_els_gp    = 4;

   typedef enum logic {
      ARB_OPEN   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // read_pkts sits in the low word so that stats_o[bank][0] is the read
   // count, [1] the write count and [2] the stall count.
   typedef struct packed {
      logic [31:0] stall_cycles;
      logic [31:0] write_pkts;
      logic [31:0] read_pkts;
   } vcache_dma_conc_stats_s;

   // Layout matches the bsg_cache DMA packet: {write_not_read, mask, addr},
   // so write_not_read is always the MSB.
   function automatic int dma_pkt_width(input int addr_width, input int mask_width);
      return 1 + mask_width + addr_width;
   endfunction

endpackage

// File: rtl/bsg_manycore_vcache_dma_burst_steer.sv
// ---------------------------------------------------------------------------
// bsg_manycore_vcache_dma_burst_steer
// Remembers which bank owns each outstanding DMA burst in one direction and
// counts the beats of the burst at the head, retiring it on its last beat.
//
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_push_v          a packet of this direction was accepted downstream
//   i_push_id         bank index of that packet
//   i_beat            one beat of the head burst handshaked this cycle
//   o_head_id         bank owning the head burst
//   o_valid           at least one burst outstanding
//   o_full            no room for another outstanding burst
// ---------------------------------------------------------------------------
module bsg_manycore_vcache_dma_burst_steer
   import bsg_manycore_vcache_pkg::*;
#(
   parameter int id_width_p  = 1,
   parameter int els_p       = vcache_dma_id_els_gp,
   parameter int burst_len_p = vcache_dma_burst_len_gp
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_push_v,
   input  logic [id_width_p-1:0] i_push_id,
   input  logic                  i_beat,
   output logic [id_width_p-1:0] o_head_id,
   output logic                  o_valid,
   output logic                  o_full
);

   localparam int ptr_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp  = $clog2(els_p + 1);
   localparam int beat_w_lp = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

   localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(burst_len_p - 1);
   localparam logic [ptr_w_lp-1:0]  last_slot_lp = ptr_w_lp'(els_p - 1);
   localparam logic [cnt_w_lp-1:0]  full_cnt_lp  = cnt_w_lp'(els_p);

   logic [id_width_p-1:0] r_mem [els_p];
   logic [ptr_w_lp-1:0]   r_rd_ptr;
   logic [ptr_w_lp-1:0]   r_wr_ptr;
   logic [cnt_w_lp-1:0]   r_count;
   logic [beat_w_lp-1:0]  r_beat_cnt;

   logic w_beat;
   logic w_last;
   logic w_pop;
   logic w_push;

   assign o_valid   = (r_count != '0);
   assign o_full    = (r_count == full_cnt_lp);
   assign o_head_id = r_mem[r_rd_ptr];

   // With burst_len_p == 1 the counter is pinned at 0, so every beat is last.
   assign w_beat = i_beat & o_valid;
   assign w_last = (r_beat_cnt == last_beat_lp);
   assign w_pop  = w_beat & w_last;
   // A full FIFO still takes a push when the head retires in the same cycle.
   assign w_push = i_push_v & (~o_full | w_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_beat_cnt <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == last_slot_lp) ? '0 : r_wr_ptr + ptr_w_lp'(1);
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == last_slot_lp) ? '0 : r_rd_ptr + ptr_w_lp'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + cnt_w_lp'(1);
            2'b01:   r_count <= r_count - cnt_w_lp'(1);
            default: r_count <= r_count;
         endcase
         if (w_beat)
            r_beat_cnt <= w_last ? '0 : r_beat_cnt + beat_w_lp'(1);
      end
   end

   // Storage needs no reset: the pointers and count define what is live.
   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_push_id;
   end

endmodule

// File: rtl/bsg_manycore_vcache_dma_concentrator.sv
// ---------------------------------------------------------------------------
// bsg_manycore_vcache_dma_concentrator
// Funnels the DMA ports of num_caches_p vcache banks into one bsg_cache DMA
// port. Packets are arbitrated round-robin (combinational, zero latency) and
// held stable once offered. Write beats are taken from the bank owning the
// oldest outstanding write; read beats are returned to the bank owning the
// oldest outstanding read. Reads and writes progress independently.
//
// Ports:
//   clk_i, reset_i                       clock, synchronous active-high reset
//   cache_dma_pkt_i/_v_i/_yumi_o         per-bank packet request
//   cache_dma_data_o/_v_o/_ready_and_i   per-bank read-beat return
//   cache_dma_data_i/_v_i/_yumi_o        per-bank write-beat source
//   mem_dma_pkt_o/_v_o/_yumi_i           shared packet port
//   mem_dma_data_i/_v_i/_ready_and_o     shared read-return port
//   mem_dma_data_o/_v_o/_yumi_i          shared write port
//   stats_o                              per-bank {stall, write, read} counts,
//                                        only with BSG_VCACHE_DMA_CONCENTRATOR_STATS_EN
//
// Arbiter states:
//   state      | meaning
//   ARB_OPEN   | no packet offered last cycle; grant follows round-robin
//   ARB_LOCKED | packet offered and not yet taken; grant held until yumi
// ---------------------------------------------------------------------------
module bsg_manycore_vcache_dma_concentrator
   import bsg_manycore_vcache_pkg::*;
#(
   parameter int num_caches_p     = 2,
   parameter int addr_width_p     = 28,
   parameter int mask_width_p     = 8,
   parameter int dma_data_width_p = 32,
   parameter int burst_len_p      = vcache_dma_burst_len_gp,
   parameter int id_fifo_els_p    = vcache_dma_id_els_gp,
   localparam int lg_num_caches_lp = (num_caches_p > 1) ? $clog2(num_caches_p) : 1,
   localparam int dma_pkt_width_lp = dma_pkt_width(addr_width_p, mask_width_p)
) (
   input  logic                                             clk_i,
   input  logic                                             reset_i,

   input  logic [num_caches_p-1:0][dma_pkt_width_lp-1:0]    cache_dma_pkt_i,
   input  logic [num_caches_p-1:0]                          cache_dma_pkt_v_i,
   output logic [num_caches_p-1:0]                          cache_dma_pkt_yumi_o,

   output logic [num_caches_p-1:0][dma_data_width_p-1:0]    cache_dma_data_o,
   output logic [num_caches_p-1:0]                          cache_dma_data_v_o,
   input  logic [num_caches_p-1:0]                          cache_dma_data_ready_and_i,

   input  logic [num_caches_p-1:0][dma_data_width_p-1:0]    cache_dma_data_i,
   input  logic [num_caches_p-1:0]                          cache_dma_data_v_i,
   output logic [num_caches_p-1:0]                          cache_dma_data_yumi_o,

   output logic [dma_pkt_width_lp-1:0]                      mem_dma_pkt_o,
   output logic                                             mem_dma_pkt_v_o,
   input  logic                                             mem_dma_pkt_yumi_i,

   input  logic [dma_data_width_p-1:0]                      mem_dma_data_i,
   input  logic                                             mem_dma_data_v_i,
   output logic                                             mem_dma_data_ready_and_o,

   output logic [dma_data_width_p-1:0]                      mem_dma_data_o,
   output logic                                             mem_dma_data_v_o,
   input  logic                                             mem_dma_data_yumi_i
`ifdef BSG_VCACHE_DMA_CONCENTRATOR_STATS_EN
   ,
   output logic [num_caches_p-1:0][2:0][31:0]               stats_o
`endif
);

   localparam int wnr_bit_lp = dma_pkt_width_lp - 1;
   localparam logic [lg_num_caches_lp-1:0] last_bank_lp = lg_num_caches_lp'(num_caches_p - 1);

   arb_state_e                  r_state;
   arb_state_e                  w_state_n;
   logic [lg_num_caches_lp-1:0] r_grant;
   logic [lg_num_caches_lp-1:0] r_rr_ptr;

   logic [num_caches_p-1:0]     w_elig;
   logic                        w_any;
   logic [lg_num_caches_lp-1:0] w_rr_pick;
   logic [lg_num_caches_lp-1:0] w_grant;
   logic [lg_num_caches_lp-1:0] w_grant_next;
   logic                        w_pkt_fire;
   logic                        w_pkt_is_write;

   logic [lg_num_caches_lp-1:0] w_rd_head;
   logic                        w_rd_valid;
   logic                        w_rd_full;
   logic                        w_rd_beat;
   logic [lg_num_caches_lp-1:0] w_wr_head;
   logic                        w_wr_valid;
   logic                        w_wr_full;
   logic                        w_wr_beat;

   // ---------------- packet arbitration ----------------
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < num_caches_p; i++)
         w_elig[i] = cache_dma_pkt_v_i[i]
                   & (cache_dma_pkt_i[i][wnr_bit_lp] ? ~w_wr_full : ~w_rd_full);
   end

   // Search starts at the round-robin pointer and wraps once around the banks.
   always_comb begin
      int idx;
      w_any     = 1'b0;
      w_rr_pick = '0;
      for (int k = 0; k < num_caches_p; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= num_caches_p)
            idx = idx - num_caches_p;
         if (!w_any && w_elig[idx]) begin
            w_any     = 1'b1;
            w_rr_pick = lg_num_caches_lp'(idx);
         end
      end
   end

   always_comb begin
      w_state_n       = r_state;
      w_grant         = w_rr_pick;
      mem_dma_pkt_v_o = w_any;
      case (r_state)
         ARB_OPEN: begin
            if (w_any && !mem_dma_pkt_yumi_i)
               w_state_n = ARB_LOCKED;
         end
         ARB_LOCKED: begin
            w_grant         = r_grant;
            mem_dma_pkt_v_o = 1'b1;
            if (mem_dma_pkt_yumi_i)
               w_state_n = ARB_OPEN;
         end
         default: w_state_n = ARB_OPEN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_state <= ARB_OPEN;
      else
         r_state <= w_state_n;
   end

   assign mem_dma_pkt_o  = cache_dma_pkt_i[w_grant];
   assign w_pkt_fire     = mem_dma_pkt_v_o & mem_dma_pkt_yumi_i;
   assign w_pkt_is_write = mem_dma_pkt_o[wnr_bit_lp];
   assign w_grant_next   = (w_grant == last_bank_lp) ? '0 : w_grant + lg_num_caches_lp'(1);

   always_comb begin
      cache_dma_pkt_yumi_o = '0;
      if (w_pkt_fire)
         cache_dma_pkt_yumi_o[w_grant] = 1'b1;
   end

   // r_grant simply tracks w_grant; while locked w_grant is r_grant, so it holds.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_grant <= w_grant;
         if (w_pkt_fire)
            r_rr_ptr <= w_grant_next;
      end
   end

   // ---------------- outstanding-burst tracking ----------------
   bsg_manycore_vcache_dma_burst_steer #(
      .id_width_p  (lg_num_caches_lp),
      .els_p       (id_fifo_els_p),
      .burst_len_p (burst_len_p)
   ) u_rd_steer (
      .i_clk     (clk_i),
      .i_reset   (reset_i),
      .i_push_v  (w_pkt_fire & ~w_pkt_is_write),
      .i_push_id (w_grant),
      .i_beat    (w_rd_beat),
      .o_head_id (w_rd_head),
      .o_valid   (w_rd_valid),
      .o_full    (w_rd_full)
   );

   bsg_manycore_vcache_dma_burst_steer #(
      .id_width_p  (lg_num_caches_lp),
      .els_p       (id_fifo_els_p),
      .burst_len_p (burst_len_p)
   ) u_wr_steer (
      .i_clk     (clk_i),
      .i_reset   (reset_i),
      .i_push_v  (w_pkt_fire & w_pkt_is_write),
      .i_push_id (w_grant),
      .i_beat    (w_wr_beat),
      .o_head_id (w_wr_head),
      .o_valid   (w_wr_valid),
      .o_full    (w_wr_full)
   );

   // ---------------- write path ----------------
   assign mem_dma_data_o   = cache_dma_data_i[w_wr_head];
   assign mem_dma_data_v_o = cache_dma_data_v_i[w_wr_head] & w_wr_valid;
   assign w_wr_beat        = mem_dma_data_v_o & mem_dma_data_yumi_i;

   always_comb begin
      cache_dma_data_yumi_o = '0;
      if (w_wr_valid)
         cache_dma_data_yumi_o[w_wr_head] = mem_dma_data_yumi_i;
   end

   // ---------------- read path ----------------
   assign mem_dma_data_ready_and_o = cache_dma_data_ready_and_i[w_rd_head] & w_rd_valid;
   assign w_rd_beat                = mem_dma_data_v_i & mem_dma_data_ready_and_o;

   always_comb begin
      cache_dma_data_v_o = '0;
      if (w_rd_valid)
         cache_dma_data_v_v_fix: cache_dma_data_v_o[w_rd_head] = mem_dma_data_v_i;
   end

   always_comb begin
      for (int i = 0; i < num_caches_p; i++)
         cache_dma_data_o[i] = mem_dma_data_i;
   end

   // Read data with nothing outstanding has no owner; it is never accepted.
   a_rd_has_owner: assert property (@(posedge clk_i) disable iff (reset_i)
                                     !(mem_dma_data_v_i && !w_rd_valid));

   // ---------------- optional statistics ----------------
`ifdef BSG_VCACHE_DMA_CONCENTRATOR_STATS_EN
   vcache_dma_conc_stats_s r_stats [num_caches_p];

   for (genvar g = 0; g < num_caches_p; g++) begin : g_stats
      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            r_stats[g] <= '0;
         end else begin
            if (cache_dma_pkt_yumi_o[g] && !w_pkt_is_write && (r_stats[g].read_pkts != '1))
               r_stats[g].read_pkts <= r_stats[g].read_pkts + 32'd1;
            if (cache_dma_pkt_yumi_o[g] && w_pkt_is_write && (r_stats[g].write_pkts != '1))
               r_stats[g].write_pkts <= r_stats[g].write_pkts + 32'd1;
            if (cache_dma_pkt_v_i[g] && !cache_dma_pkt_yumi_o[g] && (r_stats[g].stall_cycles != '1))
               r_stats[g].stall_cycles <= r_stats[g].stall_cycles + 32'd1;
         end
      end
      assign stats_o[g] = r_stats[g];
   end
`endif

endmodule
